// File: rtl/reg_file_fwd_pkg.sv
// Shared constants and types for the ID-stage register file.
//   DATA_W / ADDR_W / NUM_REGS : GPR width, index width, GPR count
//   REG_ZERO / REG_RA          : well-known register indices (also used by the
//                                ID address generator and WB)
//   fwd_src_e                  : which source feeds a read port
package reg_file_fwd_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    typedef enum logic [2:0] {
        SrcNone,  // port idle, in reset, or reading r0
        SrcEx,
        SrcMem,
        SrcWb,
        SrcReg
    } fwd_src_e;

endpackage

// File: rtl/reg_file_fwd_fwd_mux.sv
// Per-read-port forwarding mux.
// Picks the youngest in-flight producer of the requested register
// (EX > MEM > WB write-through > stored value) and flags a load-use hit.
// Ports:
//   rst_n_i                      : reset (active-low), forces the port to zero
//   read_en_i / read_addr_i      : read request from ID
//   ex_* / mem_* / wb_*          : producer enables, destinations and data
//   ex_load_flag_i               : EX producer is a load (data not ready)
//   reg_data_i                   : GPR array contents at read_addr_i
//   read_data_o                  : forwarded operand
//   stall_hit_o                  : this port needs the EX load result
module reg_file_fwd_fwd_mux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              rst_n_i,
    input  logic              read_en_i,
    input  logic [ADDR_W-1:0] read_addr_i,
    input  logic              ex_write_en_i,
    input  logic [ADDR_W-1:0] ex_write_addr_i,
    input  logic [DATA_W-1:0] ex_write_data_i,
    input  logic              ex_load_flag_i,
    input  logic              mem_write_en_i,
    input  logic [ADDR_W-1:0] mem_write_addr_i,
    input  logic [DATA_W-1:0] mem_write_data_i,
    input  logic              wb_write_en_i,
    input  logic [ADDR_W-1:0] wb_write_addr_i,
    input  logic [DATA_W-1:0] wb_write_data_i,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [DATA_W-1:0] read_data_o,
    output logic              stall_hit_o
);

    import reg_file_fwd_pkg::*;

    fwd_src_e src_sel;
    logic     addr_zero;
    logic     ex_hit;
    logic     mem_hit;
    logic     wb_hit;

    assign addr_zero = (read_addr_i == ADDR_W'(REG_ZERO));
    assign ex_hit    = ex_write_en_i  && (ex_write_addr_i  == read_addr_i);
    assign mem_hit   = mem_write_en_i && (mem_write_addr_i == read_addr_i);
    assign wb_hit    = wb_write_en_i  && (wb_write_addr_i  == read_addr_i);

    // An EX load match still claims the port: its data is not ready, but an
    // older MEM/WB value would be stale, and the stall discards this cycle.
    always_comb begin
        src_sel = SrcNone;
        if (!rst_n_i || !read_en_i || addr_zero) begin
            src_sel = SrcNone;
        end else if (ex_hit) begin
            src_sel = SrcEx;
        end else if (mem_hit) begin
            src_sel = SrcMem;
        end else if (wb_hit) begin
            src_sel = SrcWb;
        end else begin
            src_sel = SrcReg;
        end
    end

    always_comb begin
        read_data_o = '0;
        unique case (src_sel)
            SrcNone: read_data_o = '0;
            SrcEx:   read_data_o = ex_write_data_i;
            SrcMem:  read_data_o = mem_write_data_i;
            SrcWb:   read_data_o = wb_write_data_i;
            SrcReg:  read_data_o = reg_data_i;
            default: read_data_o = '0;
        endcase
    end

    // Reading r0 never stalls; ex_write_addr == read_addr makes this the same
    // as requiring a non-zero load destination.
    assign stall_hit_o = rst_n_i && read_en_i && !addr_zero && ex_hit && ex_load_flag_i;

endmodule

// File: rtl/reg_file_fwd.sv
// ID-stage register file: 32 x 32-bit GPRs, two forwarded read ports, one
// WB write port, and a load-use stall request.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   read_en_p / read_addr_p        : ID read requests (p = 1, 2)
//   read_data_p                    : forwarded operands (combinational)
//   ex_write_* / ex_load_flag      : producer in EX
//   mem_write_*                    : producer in MEM (load data included)
//   wb_write_*                     : WB commit port
//   load_stall_req                 : stall PC/IF/ID and bubble EX
module reg_file_fwd #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_en_1,
    input  logic [ADDR_W-1:0] read_addr_1,
    input  logic              read_en_2,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic              ex_write_en,
    input  logic [ADDR_W-1:0] ex_write_addr,
    input  logic [DATA_W-1:0] ex_write_data,
    input  logic              ex_load_flag,
    input  logic              mem_write_en,
    input  logic [ADDR_W-1:0] mem_write_addr,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic              wb_write_en,
    input  logic [ADDR_W-1:0] wb_write_addr,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              load_stall_req
);

    import reg_file_fwd_pkg::*;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_en;
    logic              stall_hit_1;
    logic              stall_hit_2;

    // r0 is never written, so it keeps its reset value of zero.
    assign wr_en = wb_write_en && (wb_write_addr != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wb_write_addr] <= wb_write_data;
        end
    end

    reg_file_fwd_fwd_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_mux_1 (
        .rst_n_i          (rst_n),
        .read_en_i        (read_en_1),
        .read_addr_i      (read_addr_1),
        .ex_write_en_i    (ex_write_en),
        .ex_write_addr_i  (ex_write_addr),
        .ex_write_data_i  (ex_write_data),
        .ex_load_flag_i   (ex_load_flag),
        .mem_write_en_i   (mem_write_en),
        .mem_write_addr_i (mem_write_addr),
        .mem_write_data_i (mem_write_data),
        .wb_write_en_i    (wb_write_en),
        .wb_write_addr_i  (wb_write_addr),
        .wb_write_data_i  (wb_write_data),
        .reg_data_i       (regs_q[read_addr_1]),
        .read_data_o      (read_data_1),
        .stall_hit_o      (stall_hit_1)
    );

    reg_file_fwd_fwd_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_mux_2 (
        .rst_n_i          (rst_n),
        .read_en_i        (read_en_2),
        .read_addr_i      (read_addr_2),
        .ex_write_en_i    (ex_write_en),
        .ex_write_addr_i  (ex_write_addr),
        .ex_write_data_i  (ex_write_data),
        .ex_load_flag_i   (ex_load_flag),
        .mem_write_en_i   (mem_write_en),
        .mem_write_addr_i (mem_write_addr),
        .mem_write_data_i (mem_write_data),
        .wb_write_en_i    (wb_write_en),
        .wb_write_addr_i  (wb_write_addr),
        .wb_write_data_i  (wb_write_data),
        .reg_data_i       (regs_q[read_addr_2]),
        .read_data_o      (read_data_2),
        .stall_hit_o      (stall_hit_2)
    );

    assign load_stall_req = stall_hit_1 | stall_hit_2;

endmodule

// File: tb/tb_reg_file_fwd.sv
// Scoreboard bench for reg_file_fwd: the stimulus process pushes expected
// port values into a queue; the monitor pops and compares on each falling edge.
module tb_reg_file_fwd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_en_1, read_en_2;
    logic [4:0]  read_addr_1, read_addr_2;
    logic [31:0] read_data_1, read_data_2;
    logic        ex_write_en, ex_load_flag;
    logic [4:0]  ex_write_addr;
    logic [31:0] ex_write_data;
    logic        mem_write_en;
    logic [4:0]  mem_write_addr;
    logic [31:0] mem_write_data;
    logic        wb_write_en;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        load_stall_req;

    // mask bit 0: read_data_1, bit 1: read_data_2, bit 2: load_stall_req
    typedef struct {
        string       name;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        st;
        logic [2:0]  mask;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_file_fwd u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .read_en_1      (read_en_1),
        .read_addr_1    (read_addr_1),
        .read_en_2      (read_en_2),
        .read_addr_2    (read_addr_2),
        .read_data_1    (read_data_1),
        .read_data_2    (read_data_2),
        .ex_write_en    (ex_write_en),
        .ex_write_addr  (ex_write_addr),
        .ex_write_data  (ex_write_data),
        .ex_load_flag   (ex_load_flag),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .wb_write_en    (wb_write_en),
        .wb_write_addr  (wb_write_addr),
        .wb_write_data  (wb_write_data),
        .load_stall_req (load_stall_req)
    );

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.mask[0]) begin
                    total++;
                    if (read_data_1 !== e.d1) begin
                        bad++;
                        $display("FAIL %s read_data_1: got %h want %h", e.name, read_data_1, e.d1);
                    end
                end
                if (e.mask[1]) begin
                    total++;
                    if (read_data_2 !== e.d2) begin
                        bad++;
                        $display("FAIL %s read_data_2: got %h want %h", e.name, read_data_2, e.d2);
                    end
                end
                if (e.mask[2]) begin
                    total++;
                    if (load_stall_req !== e.st) begin
                        bad++;
                        $display("FAIL %s load_stall_req: got %b want %b", e.name,
                                 load_stall_req, e.st);
                    end
                end
            end
        end
    end

    task automatic clr();
        read_en_1 = 0; read_addr_1 = 0; read_en_2 = 0; read_addr_2 = 0;
        ex_write_en = 0; ex_write_addr = 0; ex_write_data = 0; ex_load_flag = 0;
        mem_write_en = 0; mem_write_addr = 0; mem_write_data = 0;
        wb_write_en = 0; wb_write_addr = 0; wb_write_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue an expectation; the monitor checks it at the next falling edge.
    task automatic vec(input string name, input logic [31:0] d1, input logic [31:0] d2,
                       input logic st, input logic [2:0] mask);
        exp_t e;
        e.name = name; e.d1 = d1; e.d2 = d2; e.st = st; e.mask = mask;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0;
        clr();
        #1;
        // Reset forces outputs to zero even with matching forward sources
        read_en_1 = 1; read_addr_1 = 9; read_en_2 = 1; read_addr_2 = 9;
        ex_write_en = 1; ex_write_addr = 9; ex_write_data = 32'h11; ex_load_flag = 1;
        mem_write_en = 1; mem_write_addr = 9; mem_write_data = 32'h22;
        vec("in_reset", 32'h0, 32'h0, 1'b0, 3'b111);
        clr();
        tick();
        rst_n = 1;

        // Write r5, then read from storage
        wb_write_en = 1; wb_write_addr = 5; wb_write_data = 32'h1234;
        read_en_1 = 1; read_addr_1 = 5;
        vec("wt_r5", 32'h1234, 32'h0, 1'b0, 3'b001);
        tick();
        clr();
        read_en_1 = 1; read_addr_1 = 5;
        vec("store_r5", 32'h1234, 32'h0, 1'b0, 3'b101);

        // Mid-run async reset; a WB write held across a clock edge in reset is dropped
        rst_n = 0;
        #1;
        vec("async_rst", 32'h0, 32'h0, 1'b0, 3'b001);
        wb_write_en = 1; wb_write_addr = 6; wb_write_data = 32'h55;
        tick();
        clr();
        rst_n = 1;
        read_en_1 = 1; read_addr_1 = 5; read_en_2 = 1; read_addr_2 = 6;
        vec("post_rst", 32'h0, 32'h0, 1'b0, 3'b011);

        // r0 stays zero
        wb_write_en = 1; wb_write_addr = 0; wb_write_data = 32'hFFFF_FFFF;
        read_en_1 = 1; read_addr_1 = 0;
        vec("r0_wt", 32'h0, 32'h0, 1'b0, 3'b001);
        tick();
        clr();
        read_en_1 = 1; read_addr_1 = 0; read_en_2 = 1; read_addr_2 = 0;
        ex_write_en = 1; ex_write_addr = 0; ex_write_data = 32'h77;
        mem_write_en = 1; mem_write_addr = 0; mem_write_data = 32'h88;
        vec("r0_fwd", 32'h0, 32'h0, 1'b0, 3'b011);
        clr();

        // Write-through then storage
        wb_write_en = 1; wb_write_addr = 3; wb_write_data = 32'hDEAD_BEEF;
        read_en_1 = 1; read_addr_1 = 3;
        vec("wt_r3", 32'hDEAD_BEEF, 32'h0, 1'b0, 3'b001);
        tick();
        clr();
        read_en_1 = 1; read_addr_1 = 3;
        vec("store_r3", 32'hDEAD_BEEF, 32'h0, 1'b0, 3'b001);
        read_en_1 = 0;
        vec("rd_dis", 32'h0, 32'h0, 1'b0, 3'b001);

        // Priority EX > MEM > WB
        clr();
        read_en_1 = 1; read_addr_1 = 7; read_en_2 = 1; read_addr_2 = 7;
        ex_write_en = 1; ex_write_addr = 7; ex_write_data = 32'h1;
        mem_write_en = 1; mem_write_addr = 7; mem_write_data = 32'h2;
        wb_write_en = 1; wb_write_addr = 7; wb_write_data = 32'h3;
        vec("pri_ex", 32'h1, 32'h1, 1'b0, 3'b111);
        ex_write_en = 0;
        vec("pri_mem", 32'h2, 32'h2, 1'b0, 3'b011);
        mem_write_en = 0;
        vec("pri_wb", 32'h3, 32'h3, 1'b0, 3'b011);
        clr();

        // Load-use on port 2
        ex_write_en = 1; ex_write_addr = 9; ex_load_flag = 1; ex_write_data = 32'h99;
        read_en_2 = 1; read_addr_2 = 9;
        vec("lu_stall", 32'h0, 32'h0, 1'b1, 3'b100);
        tick();
        clr();
        mem_write_en = 1; mem_write_addr = 9; mem_write_data = 32'hCAFE_0000;
        read_en_2 = 1; read_addr_2 = 9;
        vec("lu_mem", 32'h0, 32'hCAFE_0000, 1'b0, 3'b110);
        clr();

        // Load-use on port 1
        ex_write_en = 1; ex_write_addr = 9; ex_load_flag = 1;
        read_en_1 = 1; read_addr_1 = 9;
        vec("lu_p1", 32'h0, 32'h0, 1'b1, 3'b100);

        // No false stalls
        read_en_1 = 0;
        vec("ns_dis", 32'h0, 32'h0, 1'b0, 3'b101);
        read_en_1 = 1; read_addr_1 = 10; read_en_2 = 1; read_addr_2 = 10;
        vec("ns_r10", 32'h0, 32'h0, 1'b0, 3'b100);
        ex_write_en = 0;
        vec("ns_noen", 32'h0, 32'h0, 1'b0, 3'b100);
        ex_write_en = 1; ex_write_addr = 0;
        read_addr_1 = 0; read_addr_2 = 0;
        vec("ns_r0", 32'h0, 32'h0, 1'b0, 3'b111);
        ex_write_addr = 9; ex_load_flag = 0; ex_write_data = 32'h4321;
        read_addr_1 = 9;
        vec("ex_alu", 32'h4321, 32'h0, 1'b0, 3'b111);
        clr();

        // Dual port: MEM beats stale WB for both ports
        wb_write_en = 1; wb_write_addr = 4; wb_write_data = 32'hB;
        tick();
        mem_write_en = 1; mem_write_addr = 4; mem_write_data = 32'hA;
        read_en_1 = 1; read_addr_1 = 4; read_en_2 = 1; read_addr_2 = 4;
        vec("dual", 32'hA, 32'hA, 1'b0, 3'b111);
        clr();
        read_en_2 = 1; read_addr_2 = 4;
        vec("store_r4", 32'h0, 32'hB, 1'b0, 3'b010);
        clr();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_fwd.md
Name: reg_file_fwd

Overview:
- ID-stage register file for the 5-stage MIPS core: 32 x 32-bit GPRs with two read ports and one write port.
- Read ports are driven by the ID-stage register-address generator (read enable + address per port); the write port is driven by WB.
- Resolves RAW hazards locally: forwards results from EX, MEM and WB into the read data, and raises a load-use stall request when forwarding cannot help.

Parameters:
- DATA_W, 32, GPR width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of GPRs; index 0 is hard-wired to zero

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- read_en_1  in  1  port-1 read request from ID
- read_addr_1  in  ADDR_W  port-1 register index
- read_en_2  in  1  port-2 read request from ID
- read_addr_2  in  ADDR_W  port-2 register index
- read_data_1  out  DATA_W  port-1 operand (forwarded)
- read_data_2  out  DATA_W  port-2 operand (forwarded)
- ex_write_en  in  1  instruction in EX writes a GPR
- ex_write_addr  in  ADDR_W  its destination
- ex_write_data  in  DATA_W  its ALU result
- ex_load_flag  in  1  instruction in EX is a load; data not yet available
- mem_write_en  in  1  instruction in MEM writes a GPR
- mem_write_addr  in  ADDR_W  its destination
- mem_write_data  in  DATA_W  its result, including load data
- wb_write_en  in  1  WB commit enable
- wb_write_addr  in  ADDR_W  WB destination
- wb_write_data  in  DATA_W  WB data
- load_stall_req  out  1  request to stall PC/IF/ID and bubble EX

Behaviour:
- Storage
  - On async reset (rst_n=0), all NUM_REGS entries clear to 0 immediately.
  - On a rising clk with rst_n=1, wb_write_en=1 and wb_write_addr!=0: regs[wb_write_addr] <= wb_write_data.
  - Writes to index 0 are ignored; regs[0] always reads 0.
  - Reset deasserting mid-program leaves all entries at 0. No write occurs while rst_n=0.
- Read path (combinational, zero latency)
  - Evaluated per port p with read_en_p and read_addr_p. Priority, first match wins:
    1. rst_n=0 -> 0
    2. read_en_p=0 -> 0
    3. read_addr_p=0 -> 0, regardless of any forward source
    4. ex_write_en and ex_write_addr==read_addr_p and !ex_load_flag -> ex_write_data
    5. mem_write_en and mem_write_addr==read_addr_p -> mem_write_data
    6. wb_write_en and wb_write_addr==read_addr_p -> wb_write_data (same-cycle write-through)
    7. otherwise regs[read_addr_p]
  - The youngest producer always wins; EX beats MEM beats WB when several match.
  - An EX load match does not fall through to MEM/WB. The data is don't-care because a stall is issued.
- Load-use stall (combinational)
  - load_stall_req = ex_load_flag & ex_write_en & (ex_write_addr!=0) & ((read_en_1 & read_addr_1==ex_write_addr) | (read_en_2 & read_addr_2==ex_write_addr)).
  - Held for exactly the cycles the condition is true (normally 1). Once the load reaches MEM, rule 5 supplies its data.
  - Forced to 0 during reset.
- Outputs are combinational; no internal pipeline registers besides the GPR array. The block has no FSM.

Decomposition:
- Shared package/header: DATA_W, ADDR_W, and the REG_ZERO / REG_RA (31) index constants. These are reused by the ID address generator and WB.
- Natural sub-module: fwd_mux (one instance per read port). It implements the priority chain and a per-port stall hit bit. The top ORs the hit bits into load_stall_req and owns the GPR array.

Test Plan:
- Reset/zero: pulse rst_n low mid-run after writing r5=0x1234 -> read r5 = 0 asynchronously. Then WB write r0=0xFFFF_FFFF -> read r0 = 0, and EX forward to r0 is also ignored.
- Write-through: same cycle WB writes r3=0xDEAD_BEEF while port 1 reads r3 -> read_data_1=0xDEAD_BEEF that cycle; next cycle it comes from storage with the same value.
- Priority: EX r7=0x1, MEM r7=0x2, WB r7=0x3 simultaneously -> 0x1. Drop EX -> 0x2. Drop MEM -> 0x3.
- Load-use: EX load to r9 with port 2 reading r9 -> load_stall_req=1 for one cycle. Next cycle, with the load in MEM and mem_write_data=0xCAFE_0000 -> read_data_2=0xCAFE_0000, load_stall_req=0.
- No false stall: EX load to r9 with read_en_1=0 on read_addr_1=9, or port reading r10 -> load_stall_req=0. EX load to r0 -> 0.
- Dual port: port 1 reads r4 (MEM forward 0xA), port 2 reads r4 (WB-stale 0xB) -> both ports = 0xA.
